control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 1, number of EXEC-state cycles (legal 1..4) allowed for ALU settling.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port instr_valid, input, 1, upstream offers an instruction.
REQ-005 SHALL have port instr_in, input, 32, offered instruction word.
REQ-006 SHALL have port instr_ready, output, 1, sequencer can accept an instruction.
REQ-007 SHALL have port instruction, output, 32, latched instruction driven to the datapath.
REQ-008 SHALL have ports RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, output, 1 each, datapath controls.
REQ-009 SHALL have port ALUCtrl, output, 4, ALU operation code.
REQ-010 SHALL have port illegal, output, 1, unsupported opcode/funct detected.

Function
REQ-011 SHALL implement states IDLE, DECODE, EXEC, MEM, WB (plus HALT, see Configuration).
REQ-012 IDLE: instr_ready=1; on instr_valid&&instr_ready, latch instr_in into instruction and go to DECODE; otherwise stay in IDLE.
REQ-013 instruction SHALL hold stable from the accept edge until the next accept.
REQ-014 Decode table (opcode[31:26], funct[5:0]): R-type 0x00 with funct add 0x20->0010, sub 0x22->0110, and 0x24->0000, or 0x25->0001, slt 0x2A->0111, nor 0x27->1100; lw 0x23, sw 0x2B, addi 0x08 use ALUCtrl 0010.
REQ-015 Static controls SHALL be valid from DECODE through end of instruction: R-type RegDst=0 ALUSrc=0 MemtoReg=0; lw RegDst=1 ALUSrc=1 MemtoReg=1; addi RegDst=1 ALUSrc=1 MemtoReg=0; sw ALUSrc=1, RegDst/MemtoReg=0.
REQ-016 DECODE -> EXEC for legal instructions; EXEC lasts exactly EXEC_CYCLES cycles.
REQ-017 EXEC -> MEM for lw/sw; EXEC -> WB for R-type/addi.
REQ-018 MEM (one cycle): lw asserts MemRead, held through WB; sw asserts MemWrite for exactly this cycle, then -> IDLE.
REQ-019 WB (one cycle): RegWrite=1 for exactly this cycle (single rising edge per instruction), then -> IDLE.
REQ-020 RegWrite and MemWrite SHALL never be asserted in the same cycle and SHALL be 0 in all other states.
REQ-021 Latency with EXEC_CYCLES=1, accept at edge N: R-type/addi WB in cycle N+3, lw WB N+4, sw MEM N+3; instr_ready=1 again the cycle after the last state.
REQ-022 instr_ready SHALL be 0 in every state except IDLE; no back-to-back accept while busy.
REQ-023 Illegal opcode/funct in DECODE: illegal=1 for one cycle, no RegWrite/MemWrite/MemRead, next state per Configuration.

Reset
REQ-024 reset SHALL force state IDLE, instruction=0, all controls and ALUCtrl=0, illegal=0, instr_ready=0 during the reset cycle.
REQ-025 Reset asserted in any state SHALL abort the instruction with no RegWrite or MemWrite pulse; reset has priority over accept.

Configuration
REQ-026 Macro CONTROL_SEQUENCER_ILLEGAL_TRAP_EN: when defined, illegal instruction -> HALT state, illegal held at 1, instr_ready=0 until reset.
REQ-027 When undefined: illegal pulses one cycle, instruction treated as NOP, return to IDLE.

Verification
REQ-028 add $3,$1,$2 (0x00221820) accepted -> ALUCtrl=0010, RegDst=0, ALUSrc=0, single RegWrite pulse 3 cycles after accept, then instr_ready=1.
REQ-029 lw $2,4($1) (0x8C220004) -> RegDst=1, ALUSrc=1, MemtoReg=1, MemRead in MEM and WB, RegWrite in cycle N+4.
REQ-030 sw $2,8($1) (0xAC220008) -> MemWrite one cycle at N+3, RegWrite never asserted.
REQ-031 opcode 0x3F -> illegal=1; with macro, stuck in HALT until reset; without, instr_ready=1 at N+2.
REQ-032 reset asserted in EXEC of add -> no RegWrite pulse, all outputs 0 next cycle, then IDLE accepts new instruction.
REQ-033 EXEC_CYCLES=3, nor (funct 0x27) -> ALUCtrl=1100, RegWrite at N+5; instr_valid held high continuously -> next accept only after return to IDLE.

Source files
------------

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: accepts one instruction at a time, decodes it and
// steps through DECODE/EXEC/MEM/WB. Optional macro CONTROL_SEQUENCER_ILLEGAL_TRAP_EN traps illegal instructions in HALT.
module control_sequencer #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr_in,
    output logic        instr_ready,
    output logic [31:0] instruction,
    output logic        RegDst,
    output logic        MemRead,
    output logic        MemtoReg,
    output logic        MemWrite,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic [3:0]  ALUCtrl,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [1:0] EXEC_LAST = 2'(EXEC_CYCLES - 1);

    state_t      state, state_n;
    logic [1:0]  exec_cnt, exec_cnt_n;
    logic [31:0] instr_q;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        is_r, is_lw, is_sw, is_addi, legal;
    logic [3:0]  alu_dec;

    logic        ready_c, illegal_c, active;
    logic        regdst_c, memread_c, memtoreg_c, memwrite_c, alusrc_c, regwrite_c;
    logic [3:0]  aluctrl_c;

    assign opcode = instr_q[31:26];
    assign funct  = instr_q[5:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            exec_cnt <= '0;
            instr_q  <= '0;
        end else begin
            state    <= state_n;
            exec_cnt <= exec_cnt_n;
            if (state == S_IDLE && instr_valid) begin
                instr_q <= instr_in;
            end
        end
    end

    always_comb begin
        is_r    = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_addi = 1'b0;
        legal   = 1'b0;
        alu_dec = '0;
        case (opcode)
            6'h00: begin
                is_r  = 1'b1;
                legal = 1'b1;
                case (funct)
                    6'h20:   alu_dec = 4'b0010;
                    6'h22:   alu_dec = 4'b0110;
                    6'h24:   alu_dec = 4'b0000;
                    6'h25:   alu_dec = 4'b0001;
                    6'h2A:   alu_dec = 4'b0111;
                    6'h27:   alu_dec = 4'b1100;
                    default: legal   = 1'b0;
                endcase
            end
            6'h23: begin
                is_lw   = 1'b1;
                legal   = 1'b1;
                alu_dec = 4'b0010;
            end
            6'h2B: begin
                is_sw   = 1'b1;
                legal   = 1'b1;
                alu_dec = 4'b0010;
            end
            6'h08: begin
                is_addi = 1'b1;
                legal   = 1'b1;
                alu_dec = 4'b0010;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_n    = state;
        exec_cnt_n = exec_cnt;
        ready_c    = 1'b0;
        illegal_c  = 1'b0;
        case (state)
            S_IDLE: begin
                ready_c = 1'b1;
                if (instr_valid) begin
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                if (legal) begin
                    state_n    = S_EXEC;
                    exec_cnt_n = '0;
                end else begin
                    illegal_c = 1'b1;
`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
                    state_n   = S_HALT;
`else
                    state_n   = S_IDLE;
`endif
                end
            end
            S_EXEC: begin
                if (exec_cnt == EXEC_LAST) begin
                    state_n = (is_lw || is_sw) ? S_MEM : S_WB;
                end else begin
                    exec_cnt_n = exec_cnt + 2'd1;
                end
            end
            S_MEM: begin
                state_n = is_lw ? S_WB : S_IDLE;
            end
            S_WB: begin
                state_n = S_IDLE;
            end
            S_HALT: begin
`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
                illegal_c = 1'b1;
`else
                state_n   = S_IDLE;
`endif
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Static controls derive from the held instruction word for the whole
    // lifetime of the instruction; pulsed controls depend on the phase too.
    always_comb begin
        active     = legal && (state == S_DECODE || state == S_EXEC ||
                               state == S_MEM    || state == S_WB);
        regdst_c   = active && (is_lw || is_addi);
        alusrc_c   = active && (is_lw || is_sw || is_addi);
        memtoreg_c = active && is_lw;
        aluctrl_c  = active ? alu_dec : 4'b0000;
        memread_c  = is_lw && (state == S_MEM || state == S_WB);
        memwrite_c = is_sw && (state == S_MEM);
        regwrite_c = legal && (is_r || is_lw || is_addi) && (state == S_WB);
    end

    // Reset masks every output combinationally so the reset cycle itself is quiet.
    always_comb begin
        instr_ready = ready_c    && !reset;
        illegal     = illegal_c  && !reset;
        RegDst      = regdst_c   && !reset;
        MemRead     = memread_c  && !reset;
        MemtoReg    = memtoreg_c && !reset;
        MemWrite    = memwrite_c && !reset;
        ALUSrc      = alusrc_c   && !reset;
        RegWrite    = regwrite_c && !reset;
        ALUCtrl     = reset ? 4'b0000 : aluctrl_c;
        instruction = reset ? '0 : instr_q;
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: one instance with EXEC_CYCLES=1 and one with EXEC_CYCLES=3.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset;

    logic        a_valid, b_valid;
    logic [31:0] a_in, b_in;
    logic        a_ready, b_ready;
    logic [31:0] a_instr, b_instr;
    logic        a_regdst, a_memread, a_memtoreg, a_memwrite, a_alusrc, a_regwrite;
    logic        b_regdst, b_memread, b_memtoreg, b_memwrite, b_alusrc, b_regwrite;
    logic [3:0]  a_alu, b_alu;
    logic        a_ill, b_ill;
    logic [5:0]  a_ctrl;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // {RegDst, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite}
    assign a_ctrl = {a_regdst, a_memread, a_memtoreg, a_memwrite, a_alusrc, a_regwrite};

    always #5 clk = ~clk;

    control_sequencer #(.EXEC_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .instr_valid(a_valid), .instr_in(a_in),
        .instr_ready(a_ready), .instruction(a_instr),
        .RegDst(a_regdst), .MemRead(a_memread), .MemtoReg(a_memtoreg),
        .MemWrite(a_memwrite), .ALUSrc(a_alusrc), .RegWrite(a_regwrite),
        .ALUCtrl(a_alu), .illegal(a_ill)
    );

    control_sequencer #(.EXEC_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .instr_valid(b_valid), .instr_in(b_in),
        .instr_ready(b_ready), .instruction(b_instr),
        .RegDst(b_regdst), .MemRead(b_memread), .MemtoReg(b_memtoreg),
        .MemWrite(b_memwrite), .ALUSrc(b_alusrc), .RegWrite(b_regwrite),
        .ALUCtrl(b_alu), .illegal(b_ill)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [31:0] rt_instr [6];
    logic [3:0]  rt_alu   [6];

    initial begin
        rt_instr = '{32'h00221820, 32'h00221822, 32'h00221824,
                     32'h00221825, 32'h0022182A, 32'h00221827};
        rt_alu   = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};

        reset   = 1'b1;
        a_valid = 1'b0; a_in = '0;
        b_valid = 1'b0; b_in = '0;
        step();
        step();
        // Reset cycle: everything quiet, and an offered instruction is not taken.
        a_valid = 1'b1; a_in = 32'h00221820;
        #1;
        chk("rst_ready", a_ready, 0);
        chk("rst_instr", a_instr, 0);
        chk("rst_ctrl", a_ctrl, 0);
        chk("rst_alu", a_alu, 0);
        chk("rst_illegal", a_ill, 0);
        step();
        reset = 1'b0; a_valid = 1'b0;
        #1;
        chk("idle_ready", a_ready, 1);
        chk("idle_instr_not_taken", a_instr, 0);

        // add $3,$1,$2
        a_in = 32'h00221820; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        chk("add_dec_instr", a_instr, 32'h00221820);
        chk("add_dec_alu", a_alu, 4'b0010);
        chk("add_dec_ctrl", a_ctrl, 6'b000000);
        chk("add_dec_ready", a_ready, 0);
        step();
        chk("add_exec_ctrl", a_ctrl, 6'b000000);
        step();
        chk("add_wb_ctrl", a_ctrl, 6'b000001);
        step();
        chk("add_idle_ready", a_ready, 1);
        chk("add_idle_ctrl", a_ctrl, 6'b000000);
        chk("add_hold_instr", a_instr, 32'h00221820);

        // lw $2,4($1)
        a_in = 32'h8C220004; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        chk("lw_dec_ctrl", a_ctrl, 6'b101010);
        chk("lw_dec_alu", a_alu, 4'b0010);
        step();
        chk("lw_exec_ctrl", a_ctrl, 6'b101010);
        step();
        chk("lw_mem_ctrl", a_ctrl, 6'b111010);
        step();
        chk("lw_wb_ctrl", a_ctrl, 6'b111011);
        step();
        chk("lw_idle_ready", a_ready, 1);
        chk("lw_idle_ctrl", a_ctrl, 6'b000000);

        // sw $2,8($1)
        a_in = 32'hAC220008; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        chk("sw_dec_ctrl", a_ctrl, 6'b000010);
        step();
        chk("sw_exec_ctrl", a_ctrl, 6'b000010);
        step();
        chk("sw_mem_ctrl", a_ctrl, 6'b000110);
        step();
        chk("sw_idle_ready", a_ready, 1);
        chk("sw_idle_ctrl", a_ctrl, 6'b000000);

        // addi $2,$1,5
        a_in = 32'h20220005; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        chk("addi_dec_ctrl", a_ctrl, 6'b100010);
        chk("addi_dec_alu", a_alu, 4'b0010);
        step();
        step();
        chk("addi_wb_ctrl", a_ctrl, 6'b100011);
        step();
        chk("addi_idle_ready", a_ready, 1);

        // R-type funct table
        for (int i = 0; i < 6; i++) begin
            a_in = rt_instr[i]; a_valid = 1'b1;
            step();
            a_valid = 1'b0;
            chk($sformatf("rt%0d_alu", i), a_alu, rt_alu[i]);
            chk($sformatf("rt%0d_dec_ctrl", i), a_ctrl, 6'b000000);
            step();
            step();
            chk($sformatf("rt%0d_wb_ctrl", i), a_ctrl, 6'b000001);
            step();
            chk($sformatf("rt%0d_idle_ready", i), a_ready, 1);
        end

        // Illegal funct under R-type (addu): NOP-like pulse back to IDLE
        a_in = 32'h00221821; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        chk("badfunct_illegal", a_ill, 1);
        chk("badfunct_ctrl", a_ctrl, 6'b000000);
        chk("badfunct_alu", a_alu, 0);
`ifndef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
        step();
        chk("badfunct_clear", a_ill, 0);
        chk("badfunct_ready", a_ready, 1);
`endif

        // Illegal opcode 0x3F
        a_in = 32'hFC000000; a_valid = 1'b1;
        if (a_ready) begin
            step();
        end else begin
            reset = 1'b1; step(); reset = 1'b0; #1;
            step();
        end
        a_valid = 1'b0;
        chk("badop_illegal", a_ill, 1);
        chk("badop_ctrl", a_ctrl, 6'b000000);
        chk("badop_ready", a_ready, 0);
        step();
`ifdef CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
        a_valid = 1'b1; a_in = 32'h00221820;
        chk("halt_illegal", a_ill, 1);
        chk("halt_ready", a_ready, 0);
        step();
        step();
        chk("halt_stuck_illegal", a_ill, 1);
        chk("halt_stuck_instr", a_instr, 32'hFC000000);
        a_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("halt_reset_ready", a_ready, 1);
        chk("halt_reset_illegal", a_ill, 0);
`else
        chk("badop_clear", a_ill, 0);
        chk("badop_ready_n2", a_ready, 1);
`endif

        // Reset while add is in EXEC aborts it without a RegWrite pulse
        a_in = 32'h00221820; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        step();
        chk("abort_exec_ctrl", a_ctrl, 6'b000000);
        reset = 1'b1;
        #1;
        chk("abort_rstcyc_alu", a_alu, 0);
        chk("abort_rstcyc_ready", a_ready, 0);
        chk("abort_rstcyc_instr", a_instr, 0);
        step();
        reset = 1'b0;
        #1;
        chk("abort_after_ctrl", a_ctrl, 6'b000000);
        chk("abort_after_alu", a_alu, 0);
        chk("abort_after_instr", a_instr, 0);
        chk("abort_after_ready", a_ready, 1);
        step();
        chk("abort_no_wb", a_regwrite, 0);
        a_in = 32'h00221822; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        chk("abort_new_instr", a_instr, 32'h00221822);
        chk("abort_new_alu", a_alu, 4'b0110);
        step();
        step();
        step();

        // EXEC_CYCLES=3: nor with instr_valid held high throughout
        b_in = 32'h00221827; b_valid = 1'b1;
        chk("b_idle_ready", b_ready, 1);
        step();
        b_in = 32'h00221820;
        chk("b_nor_alu", b_alu, 4'b1100);
        chk("b_nor_instr", b_instr, 32'h00221827);
        chk("b_dec_ready", b_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("b_exec%0d_regwrite", i), b_regwrite, 0);
            chk($sformatf("b_exec%0d_ready", i), b_ready, 0);
            chk($sformatf("b_exec%0d_instr", i), b_instr, 32'h00221827);
        end
        step();
        chk("b_wb_regwrite", b_regwrite, 1);
        chk("b_wb_ready", b_ready, 0);
        step();
        chk("b_idle_regwrite", b_regwrite, 0);
        chk("b_idle_ready2", b_ready, 1);
        chk("b_idle_instr", b_instr, 32'h00221827);
        step();
        b_valid = 1'b0;
        chk("b_next_instr", b_instr, 32'h00221820);
        chk("b_next_alu", b_alu, 4'b0010);
        chk("b_no_illegal", b_ill, 0);
        for (int i = 0; i < 5; i++) step();
        chk("b_final_ready", b_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
